// File: rtl/id_stage_pkg.sv
// id_stage_pkg: MIPS opcode, funct and ALUOp encodings shared by the ID and EX stages.
package id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b000000;
    localparam logic [5:0] FN_SUB = 6'b000001;
    localparam logic [5:0] FN_MUL = 6'b000010;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef struct packed {
        logic       legal;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       uses_rt;
        logic       dest_is_rd;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                c.legal      = instr[5:0] inside {FN_ADD, FN_SUB, FN_MUL};
                c.alu_op     = ALUOP_RTYPE;
                c.reg_write  = 1'b1;
                c.uses_rt    = 1'b1;
                c.dest_is_rd = 1'b1;
            end
            OP_LW: begin
                c.legal     = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_SW: begin
                c.legal     = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                c.legal     = 1'b1;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                c.legal   = 1'b1;
                c.alu_op  = ALUOP_BEQ;
                c.branch  = 1'b1;
                c.uses_rt = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// regfile: 32x32 register file with write-before-read bypass and optional hardwired zero register.
module regfile #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] mem [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (we && !(ZERO_REG && waddr == 5'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle writeback wins over the stored value, except into a hardwired r0.
    assign rdata1 = (ZERO_REG && raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : mem[raddr1];
    assign rdata2 = (ZERO_REG && raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : mem[raddr2];

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction decode, load-use hazard detection and ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [31:0] sign_ext,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic [5:0]  funct,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [4:0]  dest_reg,
    output logic [31:0] pcout,
    output logic        illegal
);

    ctrl_t       c;
    logic [4:0]  dest;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        accept;
    logic        load;
    logic        bad;

    assign c    = decode(instr);
    assign dest = c.dest_is_rd ? instr[15:11] : c.reg_write ? instr[20:16] : 5'd0;

    // The load sitting in ID/EX has not produced its data yet; hold the dependent instruction.
    assign stall = in_valid & out_valid & mem_read & (dest_reg != 5'd0)
                 & ((dest_reg == instr[25:21]) | (c.uses_rt & (dest_reg == instr[20:16])))
                 & ~flush;

    assign accept = in_valid & ~flush & ~stall;
    assign load   = accept & c.legal;
    assign bad    = accept & ~c.legal;

    regfile #(.ZERO_REG(ZERO_REG)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (instr[25:21]),
        .raddr2 (instr[20:16]),
        .rdata1 (rs_val),
        .rdata2 (rt_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            rs        <= '0;
            rt        <= '0;
            sign_ext  <= '0;
            ALUSrc    <= 1'b0;
            ALUOp     <= '0;
            funct     <= '0;
            branch    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            reg_write <= 1'b0;
            dest_reg  <= '0;
            pcout     <= '0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= load;
            rs        <= load ? rs_val : '0;
            rt        <= load ? rt_val : '0;
            sign_ext  <= load ? {{16{instr[15]}}, instr[15:0]} : '0;
            ALUSrc    <= load & c.alu_src;
            ALUOp     <= load ? c.alu_op : '0;
            funct     <= load ? instr[5:0] : '0;
            branch    <= load & c.branch;
            mem_read  <= load & c.mem_read;
            mem_write <= load & c.mem_write;
            reg_write <= load & c.reg_write;
            dest_reg  <= load ? dest : '0;
            pcout     <= load ? pc : '0;
            illegal   <= bad;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a behavioural decode model.
module tb_id_stage;

    localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_ADDI = 4, K_BEQ = 5;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] sext;
        logic        alusrc;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        branch;
        logic        mr;
        logic        mw;
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall, out_valid, ALUSrc, branch, mem_read, mem_write, reg_write, illegal;
    logic [31:0] rs, rt, sign_ext, pcout;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [4:0]  dest_reg;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_stall = 1'b0;
    logic        obs_stall = 1'b0;
    logic [31:0] m_regs [32];
    exp_t        m;

    always #5 clk = ~clk;

    id_stage #(.ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .out_valid(out_valid),
        .rs(rs), .rt(rt), .sign_ext(sign_ext), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .funct(funct),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .dest_reg(dest_reg), .pcout(pcout), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_regs[idx];
    endfunction

    task automatic check_outs();
        check("out_valid", out_valid, m.valid);
        check("rs", rs, m.rs);
        check("rt", rt, m.rt);
        check("sign_ext", sign_ext, m.sext);
        check("ALUSrc", ALUSrc, m.alusrc);
        check("ALUOp", ALUOp, m.aluop);
        check("funct", funct, m.funct);
        check("branch", branch, m.branch);
        check("mem_read", mem_read, m.mr);
        check("mem_write", mem_write, m.mw);
        check("reg_write", reg_write, m.rw);
        check("dest_reg", dest_reg, m.dest);
        check("pcout", pcout, m.pc);
        check("illegal", illegal, m.ill);
    endtask

    // Called at a falling edge; drives one cycle of inputs and checks the result at the next falling edge.
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p, input logic f,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        int   kind;
        logic uses_rt;
        exp_t n;
        in_valid = v; instr = i; pc = p; flush = f; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        case (i[31:26])
            6'b000000: kind = (i[5:0] <= 6'd2) ? K_R : K_ILL;
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b001000: kind = K_ADDI;
            6'b000100: kind = K_BEQ;
            default:   kind = K_ILL;
        endcase
        uses_rt   = (kind == K_R) || (kind == K_SW) || (kind == K_BEQ);
        exp_stall = v && m.valid && m.mr && m.dest != 0 && !f
                    && (m.dest == i[25:21] || (uses_rt && m.dest == i[20:16]));
        obs_stall = stall;
        check("stall", stall, exp_stall);
        n = '0;
        if (v && !f && !exp_stall) begin
            if (kind == K_ILL) n.ill = 1'b1;
            else begin
                n.valid  = 1'b1;
                n.rs     = reg_read(i[25:21]);
                n.rt     = reg_read(i[20:16]);
                n.sext   = {{16{i[15]}}, i[15:0]};
                n.alusrc = (kind == K_LW) || (kind == K_SW) || (kind == K_ADDI);
                n.aluop  = (kind == K_R) ? 2'b10 : (kind == K_BEQ) ? 2'b01 : 2'b00;
                n.funct  = i[5:0];
                n.branch = kind == K_BEQ;
                n.mr     = kind == K_LW;
                n.mw     = kind == K_SW;
                n.rw     = (kind == K_R) || (kind == K_LW) || (kind == K_ADDI);
                n.dest   = (kind == K_R) ? i[15:11] : (kind == K_LW || kind == K_ADDI) ? i[20:16] : 5'd0;
                n.pc     = p;
            end
        end
        @(posedge clk);
        if (we && wa != 0) m_regs[wa] = wd;
        m = n;
        @(negedge clk);
        check_outs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [6];
        logic [4:0] rd;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b111111};
        rd  = 5'($urandom_range(7)) ^ (($urandom_range(3) == 0) ? 5'h18 : 5'h00);
        return {ops[$urandom_range(5)], 5'($urandom_range(7)), 5'($urandom_range(7)), rd,
                5'($urandom), 6'($urandom_range(3))};
    endfunction

    task automatic model_reset();
        m = '0;
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
    endtask

    initial begin
        logic [31:0] ci, cp;
        model_reset();
        #3;
        check("rst0_ctrl", {ALUSrc, ALUOp, funct, branch, mem_read, mem_write, reg_write,
                            dest_reg, illegal, stall, out_valid}, '0);
        check("rst0_pcout", pcout, '0);
        @(negedge clk);
        reset = 1'b1;

        // ADDI r2,r1,-3 after writing r1=5
        step(0, '0, '0, 0, 1, 5'd1, 32'd5);
        step(1, {6'b001000, 5'd1, 5'd2, 16'hFFFD}, 32'h100, 0, 0, 0, 0);
        check("addi_rs", rs, 32'd5);
        check("addi_sext", sign_ext, 32'hFFFF_FFFD);
        check("addi_alusrc", ALUSrc, 1);
        check("addi_aluop", ALUOp, 0);
        check("addi_dest", dest_reg, 2);
        check("addi_rw", reg_write, 1);

        // LW r3,0(r1) then ADD r4,r3,r1: one stall, one bubble, then ADD issues
        step(1, {6'b100011, 5'd1, 5'd3, 16'h0}, 32'h104, 0, 0, 0, 0);
        step(1, {6'b000000, 5'd3, 5'd1, 5'd4, 5'd0, 6'b000000}, 32'h108, 0, 0, 0, 0);
        check("lu_stall", obs_stall, 1);
        check("lu_bubble", out_valid, 0);
        step(1, {6'b000000, 5'd3, 5'd1, 5'd4, 5'd0, 6'b000000}, 32'h108, 0, 0, 0, 0);
        check("lu_stall_end", obs_stall, 0);
        check("lu_issue", out_valid, 1);
        check("lu_funct", funct, 0);
        check("lu_dest", dest_reg, 4);

        // SUB r8,r7,r0 with r7 written in the same cycle
        step(1, {6'b000000, 5'd7, 5'd0, 5'd8, 5'd0, 6'b000001}, 32'h10C, 0, 1, 5'd7, 32'hDEAD_BEEF);
        check("byp_rs", rs, 32'hDEAD_BEEF);
        check("byp_rt", rt, 0);

        // flush together with a stall condition
        step(1, {6'b100011, 5'd1, 5'd3, 16'h0}, 32'h110, 0, 0, 0, 0);
        step(1, {6'b000000, 5'd3, 5'd1, 5'd4, 5'd0, 6'b000000}, 32'h114, 1, 0, 0, 0);
        check("fl_stall", obs_stall, 0);
        check("fl_valid", out_valid, 0);

        // illegal opcode and illegal R-type funct each pulse illegal once
        step(1, 32'hFC00_0000, 32'h118, 0, 0, 0, 0);
        check("ill_op", illegal, 1);
        check("ill_op_valid", out_valid, 0);
        step(0, '0, '0, 0, 0, 0, 0);
        check("ill_op_end", illegal, 0);
        step(1, {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b000011}, 32'h11C, 0, 0, 0, 0);
        check("ill_fn", illegal, 1);
        check("ill_fn_valid", out_valid, 0);
        step(1, {6'b001000, 5'd0, 5'd9, 16'h0001}, 32'h120, 0, 0, 0, 0);
        check("ill_fn_end", illegal, 0);

        // randomized stream; a stalled instruction is held upstream
        ci = rand_instr(); cp = $urandom;
        for (int k = 0; k < 600; k++) begin
            if (!exp_stall) begin ci = rand_instr(); cp = $urandom; end
            step(exp_stall ? 1'b1 : ($urandom_range(9) != 0), ci, cp, $urandom_range(9) == 0,
                 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
        end

        // reset in the middle of a cycle clears everything immediately
        step(1, {6'b001000, 5'd0, 5'd9, 16'h1234}, 32'h200, 0, 0, 0, 0);
        check("pre_rst_valid", out_valid, 1);
        in_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_ctrl", {ALUSrc, ALUOp, funct, branch, mem_read, mem_write, reg_write,
                           dest_reg, illegal, stall, out_valid}, '0);
        check("rst_rs", rs, '0);
        check("rst_rt", rt, '0);
        check("rst_sext", sign_ext, '0);
        check("rst_pcout", pcout, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_valid", out_valid, 0);
        reset = 1'b1;

        // first edge after reset accepts; r0 ignores writes; file was cleared
        step(1, {6'b000000, 5'd0, 5'd0, 5'd5, 5'd0, 6'b000000}, 32'h300, 0, 1, 5'd0, 32'd9);
        check("r0_byp", rs, 0);
        check("post_rst_valid", out_valid, 1);
        step(1, {6'b000000, 5'd0, 5'd1, 5'd6, 5'd0, 6'b000000}, 32'h304, 0, 0, 0, 0);
        check("r0_read", rs, 0);
        check("r1_cleared", rt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
